// File: rtl/fpu_ss_wb_arbiter_if.sv
// Writeback arbiter bundle: FPU and load completion streams in, FP regfile
// write port, fflags accumulate and cv-x-if result channel out.
interface fpu_ss_wb_arbiter_if #(
  parameter int X_ID_WIDTH  = 4,
  parameter int X_RFW_WIDTH = 32,
  parameter int FLEN        = 32
);
  typedef struct packed {
    logic [4:0]            addr;
    logic                  rd_is_fp;
    logic [X_ID_WIDTH-1:0] id;
    logic [1:0]            core_id;
  } fpu_tag_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [4:0]            rd;
    logic                  we;
  } mem_metadata_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    logic [X_RFW_WIDTH-1:0] data;
    logic [4:0]             rd;
    logic                   we;
    logic [2:0]             ecswe;
    logic [5:0]             ecsdata;
    logic                   exc;
    logic [5:0]             exccode;
  } x_result_t;

  logic          fpu_valid_i;
  logic          fpu_ready_o;
  logic [FLEN-1:0] fpu_result_i;
  fpu_tag_t      fpu_tag_i;
  logic [4:0]    fpu_status_i;
  logic          mem_valid_i;
  logic          mem_ready_o;
  logic [FLEN-1:0] mem_rdata_i;
  mem_metadata_t mem_meta_i;
  logic          mem_err_i;
  logic          fpr_we_o;
  logic [4:0]    fpr_waddr_o;
  logic [FLEN-1:0] fpr_wdata_o;
  logic          fflags_we_o;
  logic [4:0]    fflags_o;
  logic          x_result_valid_o;
  logic          x_result_ready_i;
  x_result_t     x_result_o;

  modport master (
    input  fpu_valid_i, fpu_result_i, fpu_tag_i, fpu_status_i,
    input  mem_valid_i, mem_rdata_i, mem_meta_i, mem_err_i, x_result_ready_i,
    output fpu_ready_o, mem_ready_o, fpr_we_o, fpr_waddr_o, fpr_wdata_o,
    output fflags_we_o, fflags_o, x_result_valid_o, x_result_o
  );

  modport slave (
    output fpu_valid_i, fpu_result_i, fpu_tag_i, fpu_status_i,
    output mem_valid_i, mem_rdata_i, mem_meta_i, mem_err_i, x_result_ready_i,
    input  fpu_ready_o, mem_ready_o, fpr_we_o, fpr_waddr_o, fpr_wdata_o,
    input  fflags_we_o, fflags_o, x_result_valid_o, x_result_o
  );
endinterface

// File: rtl/fpu_ss_wb_arbiter.sv
// Writeback arbiter: grants one of the FPU / load completions per cycle with
// alternating priority on ties, and registers the result toward FPR or x_result.
module fpu_ss_wb_arbiter #(
  parameter int         X_ID_WIDTH      = 4,
  parameter int         X_RFW_WIDTH     = 32,
  parameter int         FLEN            = 32,
  parameter logic [5:0] LOAD_FAULT_CODE = 6'd5
) (
  input logic clk_i,
  input logic rst_ni,
  fpu_ss_wb_arbiter_if.master bus
);
  typedef enum logic {PRIO_FPU = 1'b0, PRIO_MEM = 1'b1} prio_e;

  prio_e prio_r, prio_nxt_s;
  logic gnt_fpu_s, gnt_mem_s;
  logic fpu_to_fpr_s, mem_to_fpr_s, xres_avail_s, fpu_elig_s, mem_elig_s;
  logic fpr_we_nxt_s, xres_load_s;
  logic [4:0] fpr_waddr_nxt_s;
  logic [FLEN-1:0] fpr_wdata_nxt_s;
  logic [X_ID_WIDTH-1:0] xid_nxt_s;
  logic [X_RFW_WIDTH-1:0] xdata_nxt_s;
  logic [4:0] xrd_nxt_s;
  logic xwe_nxt_s, xexc_nxt_s;
  logic [5:0] xcode_nxt_s;

  logic fpr_we_r, fflags_we_r, xv_r, xwe_r, xexc_r;
  logic [4:0] fpr_waddr_r, fflags_r, xrd_r;
  logic [FLEN-1:0] fpr_wdata_r;
  logic [X_ID_WIDTH-1:0] xid_r;
  logic [X_RFW_WIDTH-1:0] xdata_r;
  logic [5:0] xcode_r;

  // The XRES slot frees up in the same cycle it hands off, so back-to-back works.
  assign xres_avail_s = !xv_r || bus.x_result_ready_i;
  assign fpu_to_fpr_s = bus.fpu_tag_i.rd_is_fp;
  assign mem_to_fpr_s = !bus.mem_err_i;
  assign fpu_elig_s   = bus.fpu_valid_i && (fpu_to_fpr_s || xres_avail_s);
  assign mem_elig_s   = bus.mem_valid_i && (mem_to_fpr_s || xres_avail_s);
  assign bus.fpu_ready_o = gnt_fpu_s;
  assign bus.mem_ready_o = gnt_mem_s;

  // Priority state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_r <= PRIO_FPU;
    end else begin
      prio_r <= prio_nxt_s;
    end
  end

  // Grant and priority update; priority only moves when both sources competed.
  always_comb begin
    gnt_fpu_s  = 1'b0;
    gnt_mem_s  = 1'b0;
    prio_nxt_s = prio_r;
    if (fpu_elig_s && mem_elig_s) begin
      case (prio_r)
        PRIO_FPU: begin gnt_fpu_s = 1'b1; prio_nxt_s = PRIO_MEM; end
        PRIO_MEM: begin gnt_mem_s = 1'b1; prio_nxt_s = PRIO_FPU; end
        default:  begin gnt_fpu_s = 1'b1; prio_nxt_s = PRIO_MEM; end
      endcase
    end else if (fpu_elig_s) begin
      gnt_fpu_s = 1'b1;
    end else if (mem_elig_s) begin
      gnt_mem_s = 1'b1;
    end else begin
      prio_nxt_s = prio_r;
    end
  end

  // Payload steering for the granted completion.
  always_comb begin
    fpr_we_nxt_s    = 1'b0;
    fpr_waddr_nxt_s = 5'd0;
    fpr_wdata_nxt_s = '0;
    xres_load_s     = 1'b0;
    xid_nxt_s       = '0;
    xdata_nxt_s     = '0;
    xrd_nxt_s       = 5'd0;
    xwe_nxt_s       = 1'b0;
    xexc_nxt_s      = 1'b0;
    xcode_nxt_s     = 6'd0;
    if (gnt_fpu_s) begin
      if (fpu_to_fpr_s) begin
        fpr_we_nxt_s    = 1'b1;
        fpr_waddr_nxt_s = bus.fpu_tag_i.addr;
        fpr_wdata_nxt_s = bus.fpu_result_i;
      end else begin
        xres_load_s = 1'b1;
        xid_nxt_s   = bus.fpu_tag_i.id;
        xdata_nxt_s = X_RFW_WIDTH'(bus.fpu_result_i);
        xrd_nxt_s   = bus.fpu_tag_i.addr;
        xwe_nxt_s   = 1'b1;
      end
    end else if (gnt_mem_s) begin
      if (mem_to_fpr_s) begin
        fpr_we_nxt_s    = bus.mem_meta_i.we;
        fpr_waddr_nxt_s = bus.mem_meta_i.rd;
        fpr_wdata_nxt_s = bus.mem_rdata_i;
      end else begin
        xres_load_s = 1'b1;
        xid_nxt_s   = bus.mem_meta_i.id;
        xrd_nxt_s   = bus.mem_meta_i.rd;
        xexc_nxt_s  = 1'b1;
        xcode_nxt_s = LOAD_FAULT_CODE;
      end
    end else begin
      xres_load_s = 1'b0;
    end
  end

  // Output registers: FPR pulse, fflags pulse and the XRES holding slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fpr_we_r    <= 1'b0;
      fpr_waddr_r <= 5'd0;
      fpr_wdata_r <= '0;
      fflags_we_r <= 1'b0;
      fflags_r    <= 5'd0;
      xv_r        <= 1'b0;
      xid_r       <= '0;
      xdata_r     <= '0;
      xrd_r       <= 5'd0;
      xwe_r       <= 1'b0;
      xexc_r      <= 1'b0;
      xcode_r     <= 6'd0;
    end else begin
      fpr_we_r    <= fpr_we_nxt_s;
      fflags_we_r <= gnt_fpu_s;
      if (fpr_we_nxt_s) begin
        fpr_waddr_r <= fpr_waddr_nxt_s;
        fpr_wdata_r <= fpr_wdata_nxt_s;
      end
      if (gnt_fpu_s) begin
        fflags_r <= bus.fpu_status_i;
      end
      if (xres_load_s || bus.x_result_ready_i) begin
        xv_r    <= xres_load_s;
        xid_r   <= xid_nxt_s;
        xdata_r <= xdata_nxt_s;
        xrd_r   <= xrd_nxt_s;
        xwe_r   <= xwe_nxt_s;
        xexc_r  <= xexc_nxt_s;
        xcode_r <= xcode_nxt_s;
      end
    end
  end

  // Drive the registered state onto the bundle.
  always_comb begin
    bus.fpr_we_o         = fpr_we_r;
    bus.fpr_waddr_o      = fpr_waddr_r;
    bus.fpr_wdata_o      = fpr_wdata_r;
    bus.fflags_we_o      = fflags_we_r;
    bus.fflags_o         = fflags_r;
    bus.x_result_valid_o = xv_r;
    bus.x_result_o         = '0;
    bus.x_result_o.id      = xid_r;
    bus.x_result_o.data    = xdata_r;
    bus.x_result_o.rd      = xrd_r;
    bus.x_result_o.we      = xwe_r;
    bus.x_result_o.exc     = xexc_r;
    bus.x_result_o.exccode = xcode_r;
  end
endmodule

// File: tb/tb_fpu_ss_wb_arbiter.sv
// Scenario tasks for the writeback arbiter plus a randomized run checked
// against a transaction-level model (tie-break owner, XRES slot queue).
module tb_fpu_ss_wb_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;

  fpu_ss_wb_arbiter_if #(.X_ID_WIDTH(4), .X_RFW_WIDTH(32), .FLEN(32)) bus ();

  fpu_ss_wb_arbiter #(.X_ID_WIDTH(4), .X_RFW_WIDTH(32), .FLEN(32),
                      .LOAD_FAULT_CODE(6'd5)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic idle();
    bus.fpu_valid_i = 1'b0; bus.fpu_result_i = 32'd0; bus.fpu_tag_i = '0;
    bus.fpu_status_i = 5'd0; bus.mem_valid_i = 1'b0; bus.mem_rdata_i = 32'd0;
    bus.mem_meta_i = '0; bus.mem_err_i = 1'b0; bus.x_result_ready_i = 1'b1;
  endtask

  task automatic set_fpu(input logic [4:0] addr, input logic fp, input logic [3:0] id,
                         input logic [31:0] res, input logic [4:0] st);
    bus.fpu_valid_i = 1'b1; bus.fpu_tag_i.addr = addr; bus.fpu_tag_i.rd_is_fp = fp;
    bus.fpu_tag_i.id = id; bus.fpu_tag_i.core_id = 2'($urandom);
    bus.fpu_result_i = res; bus.fpu_status_i = st;
  endtask

  task automatic set_mem(input logic err, input logic [3:0] id, input logic [4:0] rd,
                         input logic we, input logic [31:0] data);
    bus.mem_valid_i = 1'b1; bus.mem_err_i = err; bus.mem_meta_i.id = id;
    bus.mem_meta_i.rd = rd; bus.mem_meta_i.we = we; bus.mem_rdata_i = data;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #3;
    n_cmp++; if (bus.fpr_we_o !== 1'b0) begin n_err++; $display("FAIL rst_fpr_we got %b want 0", bus.fpr_we_o); end
    n_cmp++; if (bus.fflags_we_o !== 1'b0) begin n_err++; $display("FAIL rst_fflags_we got %b want 0", bus.fflags_we_o); end
    n_cmp++; if (bus.x_result_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_xv got %b want 0", bus.x_result_valid_o); end
    n_cmp++; if (bus.x_result_o !== '0) begin n_err++; $display("FAIL rst_xres got %h want 0", bus.x_result_o); end
    n_cmp++; if ({bus.fpr_waddr_o, bus.fpr_wdata_o, bus.fflags_o} !== 42'd0) begin n_err++; $display("FAIL rst_fpr_data got nonzero"); end
    do_reset();
  endtask

  task automatic test_fpu_fpr();
    @(posedge clk); #1;
    set_fpu(5'd3, 1'b1, 4'd1, 32'h40400000, 5'd0);
    #1;
    n_cmp++; if (bus.fpu_ready_o !== 1'b1) begin n_err++; $display("FAIL t1_ready got %b want 1", bus.fpu_ready_o); end
    @(posedge clk); #1;
    idle();
    n_cmp++; if ({bus.fpr_we_o, bus.fpr_waddr_o, bus.fpr_wdata_o} !== {1'b1, 5'd3, 32'h40400000})
      begin n_err++; $display("FAIL t1_fpr got we=%b a=%0d d=%h want 1/3/40400000", bus.fpr_we_o, bus.fpr_waddr_o, bus.fpr_wdata_o); end
    n_cmp++; if ({bus.fflags_we_o, bus.fflags_o, bus.x_result_valid_o} !== {1'b1, 5'd0, 1'b0})
      begin n_err++; $display("FAIL t1_ff got we=%b f=%h xv=%b want 1/0/0", bus.fflags_we_o, bus.fflags_o, bus.x_result_valid_o); end
    @(posedge clk); #1;
    n_cmp++; if (bus.fpr_we_o !== 1'b0) begin n_err++; $display("FAIL t1_pulse got %b want 0", bus.fpr_we_o); end
  endtask

  task automatic test_xres_hold();
    @(posedge clk); #1;
    set_fpu(5'd10, 1'b0, 4'd2, 32'd1, 5'h01);
    bus.x_result_ready_i = 1'b0;
    #1;
    n_cmp++; if (bus.fpu_ready_o !== 1'b1) begin n_err++; $display("FAIL t2_ready1 got %b want 1", bus.fpu_ready_o); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        n_cmp++; if ({bus.fflags_we_o, bus.fflags_o, bus.fpr_we_o} !== {1'b1, 5'h01, 1'b0})
          begin n_err++; $display("FAIL t2_ff got we=%b f=%h fpr=%b want 1/01/0", bus.fflags_we_o, bus.fflags_o, bus.fpr_we_o); end
        set_fpu(5'd11, 1'b0, 4'd3, 32'd2, 5'd0);
      end
      #1;
      n_cmp++; if ({bus.x_result_valid_o, bus.x_result_o.id, bus.x_result_o.rd, bus.x_result_o.data, bus.x_result_o.we, bus.x_result_o.exc}
                   !== {1'b1, 4'd2, 5'd10, 32'd1, 1'b1, 1'b0})
        begin n_err++; $display("FAIL t2_hold%0d got v=%b %h want v=1 id=2 rd=10 d=1 we=1", i, bus.x_result_valid_o, bus.x_result_o); end
      n_cmp++; if (bus.fpu_ready_o !== 1'b0) begin n_err++; $display("FAIL t2_blocked%0d got %b want 0", i, bus.fpu_ready_o); end
    end
    bus.x_result_ready_i = 1'b1;
    #1;
    n_cmp++; if (bus.fpu_ready_o !== 1'b1) begin n_err++; $display("FAIL t2_b2b got %b want 1", bus.fpu_ready_o); end
    @(posedge clk); #1;
    idle();
    n_cmp++; if ({bus.x_result_valid_o, bus.x_result_o.id, bus.x_result_o.rd, bus.x_result_o.data} !== {1'b1, 4'd3, 5'd11, 32'd2})
      begin n_err++; $display("FAIL t2_reload got v=%b %h want id=3 rd=11 d=2", bus.x_result_valid_o, bus.x_result_o); end
    @(posedge clk); #1;
    n_cmp++; if (bus.x_result_valid_o !== 1'b0) begin n_err++; $display("FAIL t2_drain got %b want 0", bus.x_result_valid_o); end
  endtask

  task automatic test_alternate();
    int f_left = 4;
    int m_left = 4;
    logic [4:0] exp_a = 5'd0;
    logic [31:0] exp_d = 32'd0;
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c > 0) begin
        n_cmp++; if ({bus.fpr_we_o, bus.fpr_waddr_o, bus.fpr_wdata_o} !== {1'b1, exp_a, exp_d})
          begin n_err++; $display("FAIL t3_fpr%0d got we=%b a=%0d d=%h want 1/%0d/%h", c, bus.fpr_we_o, bus.fpr_waddr_o, bus.fpr_wdata_o, exp_a, exp_d); end
      end
      idle();
      if (c < 8) begin
        if (f_left > 0) set_fpu(5'(4 - f_left), 1'b1, 4'd0, 32'h100 + 32'(4 - f_left), 5'd0);
        if (m_left > 0) set_mem(1'b0, 4'd0, 5'(20 - m_left), 1'b1, 32'h200 + 32'(4 - m_left));
        #1;
        n_cmp++; if ({bus.fpu_ready_o, bus.mem_ready_o} !== ((c % 2 == 0) ? 2'b10 : 2'b01))
          begin n_err++; $display("FAIL t3_grant%0d got f=%b m=%b want %s", c, bus.fpu_ready_o, bus.mem_ready_o, (c % 2 == 0) ? "F" : "M"); end
        if (c % 2 == 0) begin exp_a = 5'(4 - f_left); exp_d = 32'h100 + 32'(4 - f_left); f_left--; end
        else begin exp_a = 5'(20 - m_left); exp_d = 32'h200 + 32'(4 - m_left); m_left--; end
      end
    end
  endtask

  task automatic test_load_err();
    @(posedge clk); #1;
    set_mem(1'b1, 4'd7, 5'd4, 1'b1, 32'hdeadbeef);
    #1;
    n_cmp++; if (bus.mem_ready_o !== 1'b1) begin n_err++; $display("FAIL t4_ready got %b want 1", bus.mem_ready_o); end
    @(posedge clk); #1;
    idle();
    n_cmp++; if ({bus.x_result_valid_o, bus.x_result_o} !== {1'b1, 4'd7, 32'd0, 5'd4, 1'b0, 3'd0, 6'd0, 1'b1, 6'd5})
      begin n_err++; $display("FAIL t4_xres got v=%b %h want id=7 rd=4 we=0 exc=1 code=5", bus.x_result_valid_o, bus.x_result_o); end
    n_cmp++; if ({bus.fpr_we_o, bus.fflags_we_o} !== 2'b00)
      begin n_err++; $display("FAIL t4_side got fpr=%b ff=%b want 0/0", bus.fpr_we_o, bus.fflags_we_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_work_conserving();
    do_reset();
    @(posedge clk); #1;
    set_fpu(5'd1, 1'b0, 4'd4, 32'd9, 5'd0);
    bus.x_result_ready_i = 1'b0;
    @(posedge clk); #1;
    set_fpu(5'd2, 1'b0, 4'd5, 32'd8, 5'd0);
    set_mem(1'b0, 4'd1, 5'd9, 1'b1, 32'hcafe0001);
    #1;
    n_cmp++; if ({bus.x_result_valid_o, bus.fpu_ready_o, bus.mem_ready_o} !== 3'b101)
      begin n_err++; $display("FAIL t5_grant got xv=%b f=%b m=%b want 1/0/1", bus.x_result_valid_o, bus.fpu_ready_o, bus.mem_ready_o); end
    @(posedge clk); #1;
    n_cmp++; if ({bus.fpr_we_o, bus.fpr_waddr_o, bus.fpr_wdata_o} !== {1'b1, 5'd9, 32'hcafe0001})
      begin n_err++; $display("FAIL t5_fpr got we=%b a=%0d d=%h want 1/9/cafe0001", bus.fpr_we_o, bus.fpr_waddr_o, bus.fpr_wdata_o); end
    set_fpu(5'd6, 1'b1, 4'd0, 32'd6, 5'd0);
    set_mem(1'b0, 4'd0, 5'd7, 1'b1, 32'd7);
    bus.x_result_ready_i = 1'b1;
    #1;
    n_cmp++; if ({bus.fpu_ready_o, bus.mem_ready_o} !== 2'b10)
      begin n_err++; $display("FAIL t5_prio got f=%b m=%b want 1/0", bus.fpu_ready_o, bus.mem_ready_o); end
    @(posedge clk); #1;
    idle();
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    do_reset();
    @(posedge clk); #1;
    set_fpu(5'd12, 1'b0, 4'd5, 32'd3, 5'd0);
    set_mem(1'b0, 4'd0, 5'd13, 1'b1, 32'd4);
    bus.x_result_ready_i = 1'b0;
    #1;
    n_cmp++; if ({bus.fpu_ready_o, bus.mem_ready_o} !== 2'b10)
      begin n_err++; $display("FAIL t6_first got f=%b m=%b want 1/0", bus.fpu_ready_o, bus.mem_ready_o); end
    @(posedge clk); #1;
    bus.fpu_valid_i = 1'b0;
    n_cmp++; if (bus.x_result_valid_o !== 1'b1) begin n_err++; $display("FAIL t6_full got %b want 1", bus.x_result_valid_o); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({bus.x_result_valid_o, bus.fpr_we_o} !== 2'b00)
      begin n_err++; $display("FAIL t6_async got xv=%b fpr=%b want 0/0", bus.x_result_valid_o, bus.fpr_we_o); end
    idle();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++; if ({bus.x_result_valid_o, bus.fpr_we_o} !== 2'b00)
        begin n_err++; $display("FAIL t6_stale%0d got xv=%b fpr=%b want 0/0", i, bus.x_result_valid_o, bus.fpr_we_o); end
    end
    set_fpu(5'd1, 1'b1, 4'd0, 32'd1, 5'd0);
    set_mem(1'b0, 4'd0, 5'd2, 1'b1, 32'd2);
    #1;
    n_cmp++; if ({bus.fpu_ready_o, bus.mem_ready_o} !== 2'b10)
      begin n_err++; $display("FAIL t6_prio got f=%b m=%b want 1/0", bus.fpu_ready_o, bus.mem_ready_o); end
    @(posedge clk); #1;
    idle();
    @(posedge clk); #1;
  endtask

  typedef struct packed {
    logic [3:0] id; logic [31:0] data; logic [4:0] rd; logic we; logic exc; logic [5:0] code;
  } xrec_t;

  task automatic test_random();
    xrec_t xq[$];
    xrec_t r;
    int tie_winner = 0;
    logic exp_we = 1'b0, exp_ffwe = 1'b0;
    logic [4:0] exp_a = 5'd0, exp_ff = 5'd0;
    logic [31:0] exp_d = 32'd0;
    logic free, fe, me, gf, gm;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      n_cmp++; if (bus.fpr_we_o !== exp_we || (exp_we && {bus.fpr_waddr_o, bus.fpr_wdata_o} !== {exp_a, exp_d}))
        begin n_err++; $display("FAIL rnd_fpr c=%0d got we=%b a=%0d d=%h want %b/%0d/%h", c, bus.fpr_we_o, bus.fpr_waddr_o, bus.fpr_wdata_o, exp_we, exp_a, exp_d); end
      n_cmp++; if (bus.fflags_we_o !== exp_ffwe || (exp_ffwe && bus.fflags_o !== exp_ff))
        begin n_err++; $display("FAIL rnd_ff c=%0d got we=%b f=%h want %b/%h", c, bus.fflags_we_o, bus.fflags_o, exp_ffwe, exp_ff); end
      n_cmp++; if (bus.x_result_valid_o !== (xq.size() != 0))
        begin n_err++; $display("FAIL rnd_xv c=%0d got %b want %b", c, bus.x_result_valid_o, xq.size() != 0); end
      else if (xq.size() != 0) begin
        r = xq[0];
        n_cmp++; if (bus.x_result_o !== {r.id, r.data, r.rd, r.we, 3'd0, 6'd0, r.exc, r.code})
          begin n_err++; $display("FAIL rnd_xres c=%0d got %h want id=%h d=%h rd=%0d we=%b exc=%b", c, bus.x_result_o, r.id, r.data, r.rd, r.we, r.exc); end
      end
      idle();
      bus.x_result_ready_i = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 3) != 0)
        set_fpu(5'($urandom), 1'($urandom), 4'($urandom), $urandom, 5'($urandom));
      if ($urandom_range(0, 3) != 0)
        set_mem(($urandom_range(0, 4) == 0), 4'($urandom), 5'($urandom), 1'($urandom), $urandom);
      #1;
      free = (xq.size() == 0) || bus.x_result_ready_i;
      fe = bus.fpu_valid_i && (bus.fpu_tag_i.rd_is_fp || free);
      me = bus.mem_valid_i && (!bus.mem_err_i || free);
      gf = fe && (!me || tie_winner == 0);
      gm = me && !gf;
      if (fe && me) tie_winner = gf ? 1 : 0;
      n_cmp++; if ({bus.fpu_ready_o, bus.mem_ready_o} !== {gf, gm})
        begin n_err++; $display("FAIL rnd_grant c=%0d got f=%b m=%b want %b/%b", c, bus.fpu_ready_o, bus.mem_ready_o, gf, gm); end
      if (xq.size() != 0 && bus.x_result_ready_i) void'(xq.pop_front());
      exp_we = 1'b0;
      exp_ffwe = gf;
      if (gf) begin
        exp_ff = bus.fpu_status_i;
        if (bus.fpu_tag_i.rd_is_fp) begin exp_we = 1'b1; exp_a = bus.fpu_tag_i.addr; exp_d = bus.fpu_result_i; end
        else xq.push_back('{bus.fpu_tag_i.id, bus.fpu_result_i, bus.fpu_tag_i.addr, 1'b1, 1'b0, 6'd0});
      end
      if (gm) begin
        if (bus.mem_err_i) xq.push_back('{bus.mem_meta_i.id, 32'd0, bus.mem_meta_i.rd, 1'b0, 1'b1, 6'd5});
        else if (bus.mem_meta_i.we) begin exp_we = 1'b1; exp_a = bus.mem_meta_i.rd; exp_d = bus.mem_rdata_i; end
      end
    end
    @(posedge clk); #1;
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_fpu_fpr();
    test_xres_hold();
    test_alternate();
    test_load_err();
    test_work_conserving();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
